ifetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the single-port, word-addressed instruction memory for the pipelined CPU. It owns the fetch PC and issues one read per cycle into the memory, which has one-cycle read latency. It captures returned words with their PC in a 2-entry buffer and hands them to decode over a valid/ready handshake. It also handles branch redirects (flush and discard of in-flight data), the `run` gate, and address-range faults.

---
 rtl/ifetch_if.sv | 25 ++
 rtl/ifetch_ctrl.sv | 125 ++++++++++++
 tb/tb_ifetch_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// Fetch-side bus bundle: run/redirect control, instruction memory port and
// the valid/ready hand-off to decode. The controller takes the master side.
interface ifetch_if;
  logic        run;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        fault;

  modport master (
    input  run, redirect_valid, redirect_pc, mem_rdata, out_ready,
    output mem_en, mem_addr, out_valid, out_pc, out_instr, fault
  );

  modport slave (
    output run, redirect_valid, redirect_pc, mem_rdata, out_ready,
    input  mem_en, mem_addr, out_valid, out_pc, out_instr, fault
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues one read per cycle
// into a one-cycle-latency memory, buffers returned words in a 2-entry FIFO
// and hands them to decode. Handles redirects, the run gate and PC faults.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | after reset or run low; no memory reads issued
// S_FETCH | reads issued whenever buffer credit allows
// S_FAULT | sticky fault; no reads, buffered words drain
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  ifetch_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FAULT} state_t;

  localparam logic [32:0] PC_LIMIT = 33'(DEPTH) * 33'd4;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  occ_q, occ_d;
  logic        infl_q, infl_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  logic [31:0] head_pc_q, head_pc_d, head_instr_q, head_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d, tail_instr_q, tail_instr_d;

  logic       pop, push, redir, redir_bad;
  logic       try_issue, issue, range_fault, pc_oob;
  logic [2:0] credit_sum;
  logic [1:0] occ_after_pop;

  // Handshake, credit and issue decisions. A redirect in S_FAULT is ignored,
  // but any redirect request still blocks issue in its own cycle.
  assign pop           = (occ_q != 2'd0) && bus.out_ready;
  assign redir         = bus.redirect_valid && (state_q != S_FAULT);
  assign redir_bad     = redir && (bus.redirect_pc[1:0] != 2'b00);
  assign push          = infl_q && !redir;
  assign credit_sum    = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
  assign pc_oob        = {1'b0, fetch_pc_q} >= PC_LIMIT;
  assign try_issue     = rst_n && (state_q == S_FETCH) && bus.run &&
                         !bus.redirect_valid && (credit_sum < 3'd2);
  assign issue         = try_issue && !pc_oob;
  assign range_fault   = try_issue && pc_oob;
  assign occ_after_pop = occ_q - {1'b0, pop};

  assign bus.mem_en    = issue;
  assign bus.mem_addr  = issue ? fetch_pc_q : 32'h0;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_pc    = head_pc_q;
  assign bus.out_instr = head_instr_q;
  assign bus.fault     = (state_q == S_FAULT);

  // Next-state logic for the FSM, fetch PC, in-flight tracker and FIFO.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    infl_d       = issue;
    infl_pc_d    = issue ? fetch_pc_q : infl_pc_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;

    if (pop) begin
      head_pc_d    = tail_pc_q;
      head_instr_d = tail_instr_q;
    end
    if (push) begin
      if (occ_after_pop == 2'd0) begin
        head_pc_d    = infl_pc_q;
        head_instr_d = bus.mem_rdata;
      end else begin
        tail_pc_d    = infl_pc_q;
        tail_instr_d = bus.mem_rdata;
      end
    end
    occ_d = redir ? 2'd0 : (occ_after_pop + {1'b0, push});

    if (redir && !redir_bad) begin
      fetch_pc_d = bus.redirect_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redir_bad || range_fault) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.run)  state_d = S_FETCH;
        S_FETCH: if (!bus.run) state_d = S_IDLE;
        default: state_d = S_FAULT;
      endcase
    end
  end

  // State registers; reset discards buffered and in-flight data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      occ_q        <= 2'd0;
      infl_q       <= 1'b0;
      infl_pc_q    <= 32'h0;
      head_pc_q    <= 32'h0;
      head_instr_q <= 32'h0;
      tail_pc_q    <= 32'h0;
      tail_instr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      occ_q        <= occ_d;
      infl_q       <= infl_d;
      infl_pc_q    <= infl_pc_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: one 64-word instance for streaming,
// backpressure, redirect, run toggle, reset and misaligned redirect, and a
// 4-word instance for the out-of-range fault.
module tb_ifetch_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  ifetch_if a_if ();
  ifetch_if b_if ();

  ifetch_ctrl #(.RESET_PC(32'h0), .DEPTH(64)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.master));
  ifetch_ctrl #(.RESET_PC(32'h0), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.master));

  always #5 clk = ~clk;

  // Memory models: word i holds 32'h1000_0000 + i, one-cycle read latency.
  always @(posedge clk) if (a_if.mem_en) a_if.mem_rdata <= 32'h1000_0000 + {2'b00, a_if.mem_addr[31:2]};
  always @(posedge clk) if (b_if.mem_en) b_if.mem_rdata <= 32'h1000_0000 + {2'b00, b_if.mem_addr[31:2]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.run = 1'b0; a_if.redirect_valid = 1'b0; a_if.redirect_pc = 32'h0; a_if.out_ready = 1'b0;
    b_if.run = 1'b0; b_if.redirect_valid = 1'b0; b_if.redirect_pc = 32'h0; b_if.out_ready = 1'b0;
    next_cycle(); next_cycle(); #1;
    chk("rst_mem_en", a_if.mem_en, 0);
    chk("rst_mem_addr", a_if.mem_addr, 0);
    chk("rst_out_valid", a_if.out_valid, 0);
    chk("rst_out_pc", a_if.out_pc, 0);
    chk("rst_out_instr", a_if.out_instr, 0);
    chk("rst_fault", a_if.fault, 0);
    chk("rst_b_fault", b_if.fault, 0);

    // Streaming: cycle 0 samples run, first issue in cycle 1, data from cycle 3.
    next_cycle(); rst_n = 1'b1; a_if.run = 1'b1; a_if.out_ready = 1'b1; #1;
    chk("start_idle_mem_en", a_if.mem_en, 0);
    next_cycle(); #1;
    chk("c1_mem_en", a_if.mem_en, 1);
    chk("c1_mem_addr", a_if.mem_addr, 32'h0);
    next_cycle(); #1;
    chk("c2_mem_addr", a_if.mem_addr, 32'h4);
    chk("c2_out_valid", a_if.out_valid, 0);
    for (int k = 0; k < 6; k++) begin
      next_cycle(); #1;
      chk("stream_valid", a_if.out_valid, 1);
      chk("stream_pc", a_if.out_pc, 32'(4 * k));
      chk("stream_instr", a_if.out_instr, 32'h1000_0000 + 32'(k));
      chk("stream_addr", a_if.mem_addr, 32'(4 * (k + 2)));
    end

    // Backpressure for 5 cycles (9..13): head 24, second word 28 held.
    next_cycle(); a_if.out_ready = 1'b0; #1;
    chk("bp_mem_en_first", a_if.mem_en, 0);
    chk("bp_pc_first", a_if.out_pc, 32'd24);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); #1;
      chk("bp_mem_en", a_if.mem_en, 0);
      chk("bp_valid", a_if.out_valid, 1);
      chk("bp_pc", a_if.out_pc, 32'd24);
    end
    next_cycle(); a_if.out_ready = 1'b1; #1;
    chk("rel_pc24", a_if.out_pc, 32'd24);
    chk("rel_mem_en", a_if.mem_en, 1);
    chk("rel_addr32", a_if.mem_addr, 32'd32);
    next_cycle(); #1;
    chk("rel_pc28", a_if.out_pc, 32'd28);
    chk("rel_addr36", a_if.mem_addr, 32'd36);
    next_cycle(); #1;
    chk("rel_pc32", a_if.out_pc, 32'd32);
    chk("rel_instr32", a_if.out_instr, 32'h1000_0008);
    chk("rel_addr40", a_if.mem_addr, 32'd40);

    // Redirect with one word buffered (36) and one in flight (40), decode stalled.
    next_cycle(); a_if.out_ready = 1'b0; a_if.redirect_valid = 1'b1; a_if.redirect_pc = 32'h20; #1;
    chk("redir_d_mem_en", a_if.mem_en, 0);
    chk("redir_d_pc36", a_if.out_pc, 32'd36);
    next_cycle(); a_if.redirect_valid = 1'b0; a_if.out_ready = 1'b1; #1;
    chk("redir_d1_valid", a_if.out_valid, 0);
    chk("redir_d1_mem_en", a_if.mem_en, 1);
    chk("redir_d1_addr", a_if.mem_addr, 32'h20);
    next_cycle(); #1;
    chk("redir_d2_valid", a_if.out_valid, 0);
    chk("redir_d2_addr", a_if.mem_addr, 32'h24);
    next_cycle(); #1;
    chk("redir_d3_valid", a_if.out_valid, 1);
    chk("redir_d3_pc", a_if.out_pc, 32'h20);
    chk("redir_d3_instr", a_if.out_instr, 32'h1000_0008);
    chk("redir_d3_addr", a_if.mem_addr, 32'h28);

    // Run low for 3 cycles after issuing 0x28.
    next_cycle(); a_if.run = 1'b0; #1;
    chk("runlo_mem_en0", a_if.mem_en, 0);
    chk("runlo_pc24", a_if.out_pc, 32'h24);
    next_cycle(); #1;
    chk("runlo_pc28", a_if.out_pc, 32'h28);
    chk("runlo_instr28", a_if.out_instr, 32'h1000_000A);
    chk("runlo_mem_en1", a_if.mem_en, 0);
    next_cycle(); #1;
    chk("runlo_drained", a_if.out_valid, 0);
    chk("runlo_mem_en2", a_if.mem_en, 0);
    next_cycle(); a_if.run = 1'b1; #1;
    chk("runhi_idle_mem_en", a_if.mem_en, 0);
    next_cycle(); #1;
    chk("resume_mem_en", a_if.mem_en, 1);
    chk("resume_addr", a_if.mem_addr, 32'h2C);
    next_cycle(); #1;
    chk("resume_addr2", a_if.mem_addr, 32'h30);
    next_cycle(); #1;
    chk("resume_pc", a_if.out_pc, 32'h2C);
    chk("resume_instr", a_if.out_instr, 32'h1000_000B);

    // Reset mid-stream.
    rst_n = 1'b0; #1;
    chk("midrst_mem_en", a_if.mem_en, 0);
    next_cycle(); rst_n = 1'b1; #1;
    chk("midrst_mem_en_next", a_if.mem_en, 0);
    chk("midrst_mem_addr", a_if.mem_addr, 0);
    chk("midrst_valid", a_if.out_valid, 0);
    chk("midrst_pc", a_if.out_pc, 0);
    chk("midrst_instr", a_if.out_instr, 0);
    chk("midrst_fault", a_if.fault, 0);
    next_cycle(); #1;
    chk("postrst_mem_en", a_if.mem_en, 1);
    chk("postrst_addr", a_if.mem_addr, 32'h0);
    chk("postrst_valid", a_if.out_valid, 0);

    // Misaligned redirect, then a legal redirect that must be ignored.
    next_cycle(); a_if.redirect_valid = 1'b1; a_if.redirect_pc = 32'h22; #1;
    chk("mis_d_mem_en", a_if.mem_en, 0);
    chk("mis_d_fault", a_if.fault, 0);
    next_cycle(); a_if.redirect_valid = 1'b0; #1;
    chk("mis_fault", a_if.fault, 1);
    chk("mis_mem_en", a_if.mem_en, 0);
    chk("mis_killed", a_if.out_valid, 0);
    next_cycle(); a_if.redirect_valid = 1'b1; a_if.redirect_pc = 32'h40; #1;
    chk("fault_redir_mem_en", a_if.mem_en, 0);
    next_cycle(); a_if.redirect_valid = 1'b0; #1;
    chk("fault_sticky1", a_if.fault, 1);
    chk("fault_mem_en1", a_if.mem_en, 0);
    next_cycle(); #1;
    chk("fault_sticky2", a_if.fault, 1);
    chk("fault_mem_en2", a_if.mem_en, 0);
    next_cycle(); rst_n = 1'b0; a_if.run = 1'b0; #1;
    next_cycle(); rst_n = 1'b1; b_if.run = 1'b1; b_if.out_ready = 1'b1; #1;
    chk("fault_cleared", a_if.fault, 0);

    // Out-of-range with DEPTH=4: PCs 0..12 delivered, then fault.
    for (int c = 0; c < 9; c++) begin
      logic        e_en, e_valid, e_fault;
      logic [31:0] e_addr;
      if (c > 0) begin
        next_cycle(); #1;
      end
      e_en    = (c >= 1) && (c <= 4);
      e_addr  = e_en ? 32'(4 * (c - 1)) : 32'h0;
      e_valid = (c >= 3) && (c <= 6);
      e_fault = (c >= 6);
      chk("oob_mem_en", b_if.mem_en, e_en);
      chk("oob_mem_addr", b_if.mem_addr, e_addr);
      chk("oob_valid", b_if.out_valid, e_valid);
      chk("oob_fault", b_if.fault, e_fault);
      if (e_valid) begin
        chk("oob_pc", b_if.out_pc, 32'(4 * (c - 3)));
        chk("oob_instr", b_if.out_instr, 32'h1000_0000 + 32'(c - 3));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
